// File: rtl/data_memory_stage.sv
// data_memory_stage
// MEM-stage data memory for the 64-bit pipelined RISC-V core. It is
// byte-addressable and little-endian. Every access takes a fixed number of
// cycles. While an access is in flight, a stall goes to the hazard unit.
//
// Ports
//   clk         rising-edge clock
//   reset       asynchronous, active-high reset
//   Mem_Addr    byte address; the low log2(DEPTH_BYTES) bits are used, so
//               accesses wrap around the array
//   Write_Data  store data; the low bytes are used according to the size
//   MemRead     load request
//   MemWrite    store request; it wins over MemRead when both are high
//   funct3      RISC-V load/store size and signedness
//   Read_Data   extended load value; valid in the final cycle of a load
//   mem_stall   high in every cycle of an access except the final one
//   misaligned  the current access is misaligned and has been suppressed
//
// state  | meaning
// S_IDLE | no access in flight; a new request is accepted this cycle
// S_WAIT | access in flight; cnt counts the cycles already spent on it
module data_memory_stage #(
   parameter int DEPTH_BYTES = 256,
   parameter int LATENCY     = 3
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [63:0] Mem_Addr,
   input  logic [63:0] Write_Data,
   input  logic        MemRead,
   input  logic        MemWrite,
   input  logic [2:0]  funct3,
   output logic [63:0] Read_Data,
   output logic        mem_stall,
   output logic        misaligned
);

   localparam int AW = $clog2(DEPTH_BYTES);
   localparam int CW = $clog2(LATENCY) + 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(LATENCY - 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   typedef enum logic {S_IDLE, S_WAIT} state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [7:0]    mem_q [DEPTH_BYTES];

   logic [AW-1:0] idx;
   logic          unused_addr_hi;
   logic          access_req;
   logic          reserved_ld;
   logic          addr_mis;
   logic          mis_int;
   logic          aligned_req;
   logic          stall_int;
   logic          final_cyc;
   logic          commit;
   logic [7:0]    byte_en;
   logic [63:0]   raw;
   logic [63:0]   ld_ext;

   // The upper address bits are ignored, so the array wraps around.
   assign idx            = Mem_Addr[AW-1:0];
   assign unused_addr_hi = ^Mem_Addr[63:AW];

   assign access_req = MemRead | MemWrite;
   // funct3=111 means nothing for a load. Such a load returns zero and is
   // never flagged. With MemWrite high, the same code is simply sd.
   assign reserved_ld = MemRead & ~MemWrite & (funct3 == 3'b111);

   always_comb begin
      addr_mis = 1'b0;
      byte_en  = 8'h00;
      unique case (funct3[1:0])
         2'b00: begin addr_mis = 1'b0;             byte_en = 8'h01; end
         2'b01: begin addr_mis = Mem_Addr[0];      byte_en = 8'h03; end
         2'b10: begin addr_mis = |Mem_Addr[1:0];   byte_en = 8'h0F; end
         2'b11: begin addr_mis = |Mem_Addr[2:0];   byte_en = 8'hFF; end
         default: begin addr_mis = 1'b0;           byte_en = 8'h00; end
      endcase
   end

   assign mis_int     = access_req & ~reserved_ld & addr_mis;
   assign aligned_req = access_req & ~mis_int;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      stall_int = 1'b0;
      final_cyc = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (aligned_req) begin
               if (LATENCY == 1) begin
                  final_cyc = 1'b1;
               end else begin
                  stall_int = 1'b1;
                  state_d   = S_WAIT;
                  cnt_d     = CNT_ONE;
               end
            end
         end
         S_WAIT: begin
            if (cnt_q == CNT_LAST) begin
               final_cyc = 1'b1;
               state_d   = S_IDLE;
               cnt_d     = '0;
            end else begin
               stall_int = 1'b1;
               cnt_d     = cnt_q + CNT_ONE;
            end
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // Gather 8 bytes starting at the index. An aligned access never crosses
   // the top of the array, because DEPTH_BYTES is a power of two and at least 8.
   always_comb begin
      raw = '0;
      for (int i = 0; i < 8; i++) begin
         raw[8*i +: 8] = mem_q[idx + AW'(i)];
      end
   end

   always_comb begin
      ld_ext = '0;
      unique case (funct3)
         3'b000: ld_ext = {{56{raw[7]}},  raw[7:0]};
         3'b001: ld_ext = {{48{raw[15]}}, raw[15:0]};
         3'b010: ld_ext = {{32{raw[31]}}, raw[31:0]};
         3'b011: ld_ext = raw;
         3'b100: ld_ext = {56'd0, raw[7:0]};
         3'b101: ld_ext = {48'd0, raw[15:0]};
         3'b110: ld_ext = {32'd0, raw[31:0]};
         default: ld_ext = '0;
      endcase
   end

   // All outputs are forced low while reset is held. This also makes
   // mem_stall drop at once when reset aborts an access.
   assign mem_stall  = ~reset & stall_int;
   assign misaligned = ~reset & mis_int;
   assign Read_Data  = (~reset & MemRead & ~MemWrite & final_cyc) ? ld_ext : '0;
   assign commit     = final_cyc & MemWrite;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         for (int i = 0; i < DEPTH_BYTES; i++) begin
            mem_q[i] <= 8'h00;
         end
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (commit) begin
            for (int i = 0; i < 8; i++) begin
               if (byte_en[i]) begin
                  mem_q[idx + AW'(i)] <= Write_Data[8*i +: 8];
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_data_memory_stage.sv
module tb_data_memory_stage;

   logic        clk;
   logic        rst;

   logic [63:0] addr, wdata, rd;
   logic        mr, mw, stall, mis;
   logic [2:0]  f3;

   logic [63:0] addr1, wdata1, rd1;
   logic        mr1, mw1, stall1, mis1;
   logic [2:0]  f31;

   int total = 0;
   int bad   = 0;

   typedef struct {
      string       tag;
      logic [63:0] data;
      int          stalls;
      logic        mis;
   } exp_t;

   exp_t sb_q[$];

   data_memory_stage #(.DEPTH_BYTES(256), .LATENCY(3)) dut (
      .clk(clk), .reset(rst), .Mem_Addr(addr), .Write_Data(wdata),
      .MemRead(mr), .MemWrite(mw), .funct3(f3),
      .Read_Data(rd), .mem_stall(stall), .misaligned(mis)
   );

   data_memory_stage #(.DEPTH_BYTES(256), .LATENCY(1)) dut1 (
      .clk(clk), .reset(rst), .Mem_Addr(addr1), .Write_Data(wdata1),
      .MemRead(mr1), .MemWrite(mw1), .funct3(f31),
      .Read_Data(rd1), .mem_stall(stall1), .misaligned(mis1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   // Drive one access, queue its expectation, wait for the final cycle and
   // then compare. Returns 1 ns after the edge that ends the access.
   task automatic access(input bit sel, input string tag, input logic r, input logic w,
                         input logic [2:0] fn, input logic [63:0] a, input logic [63:0] wd,
                         input logic [63:0] exp_data, input int exp_stalls, input logic exp_mis);
      exp_t e;
      int   stalls;
      bit   done;
      if (sel) begin
         mr1 = r; mw1 = w; f31 = fn; addr1 = a; wdata1 = wd;
      end else begin
         mr = r; mw = w; f3 = fn; addr = a; wdata = wd;
      end
      e.tag = tag; e.data = exp_data; e.stalls = exp_stalls; e.mis = exp_mis;
      sb_q.push_back(e);
      stalls = 0;
      done   = 1'b0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (!(sel ? stall1 : stall)) begin
            done = 1'b1;
            break;
         end
         stalls++;
      end
      total++;
      assert (done) else begin
         bad++;
         $error("FAIL %s.timeout: observed stall still high, expected low within 20 cycles", tag);
      end
      e = sb_q.pop_front();
      chk({e.tag, ".data"},   sel ? rd1 : rd,   e.data);
      chk({e.tag, ".stalls"}, 64'(stalls),      64'(e.stalls));
      chk({e.tag, ".mis"},    {63'd0, sel ? mis1 : mis}, {63'd0, e.mis});
      @(posedge clk);
      #1;
   endtask

   task automatic idle_all();
      mr = 0; mw = 0; f3 = 3'b011; addr = '0; wdata = '0;
      mr1 = 0; mw1 = 0; f31 = 3'b011; addr1 = '0; wdata1 = '0;
   endtask

   initial begin
      logic [63:0] v;
      idle_all();
      rst = 1'b1;
      // A misaligned load is driven during reset: every output must still be 0.
      mr = 1; f3 = 3'b011; addr = 64'h11;
      #12;
      chk("rst.rd",    rd,             64'd0);
      chk("rst.stall", {63'd0, stall}, 64'd0);
      chk("rst.mis",   {63'd0, mis},   64'd0);
      @(negedge clk);
      idle_all();
      rst = 1'b0;
      @(posedge clk);
      #1;

      access(0, "ld10", 1, 0, 3'b011, 64'h10, 0, 64'd0, 2, 0);

      access(0, "sd20", 0, 1, 3'b011, 64'h20, 64'h8877665544332211, 64'd0, 2, 0);
      access(0, "lb27",  1, 0, 3'b000, 64'h27, 0, 64'hFFFFFFFFFFFFFF88, 2, 0);
      access(0, "lbu27", 1, 0, 3'b100, 64'h27, 0, 64'h0000000000000088, 2, 0);
      access(0, "lh26",  1, 0, 3'b001, 64'h26, 0, 64'hFFFFFFFFFFFF8877, 2, 0);
      access(0, "lw24",  1, 0, 3'b010, 64'h24, 0, 64'hFFFFFFFF88776655, 2, 0);
      access(0, "lhu26", 1, 0, 3'b101, 64'h26, 0, 64'h0000000000008877, 2, 0);
      access(0, "lwu24", 1, 0, 3'b110, 64'h24, 0, 64'h0000000088776655, 2, 0);

      access(0, "sb21", 0, 1, 3'b000, 64'h21, 64'h00000000000000AB, 64'd0, 2, 0);
      access(0, "ld20", 1, 0, 3'b011, 64'h20, 0, 64'h887766554433AB11, 2, 0);

      access(0, "sd00", 0, 1, 3'b011, 64'h00, 64'h0102030405060708, 64'd0, 2, 0);
      access(0, "lw22mis", 1, 0, 3'b010, 64'h22, 0, 64'd0, 0, 1);
      access(0, "sd104mis", 0, 1, 3'b011, 64'h104, 64'hDEADBEEFCAFEF00D, 64'd0, 0, 1);
      access(0, "ld100wrap", 1, 0, 3'b011, 64'h100, 0, 64'h0102030405060708, 2, 0);
      access(0, "ld20again", 1, 0, 3'b011, 64'h20, 0, 64'h887766554433AB11, 2, 0);

      access(0, "rsvd", 1, 0, 3'b111, 64'h20, 0, 64'd0, 2, 0);
      access(0, "rdwr30", 1, 1, 3'b011, 64'h30, 64'h0000000000001234, 64'd0, 2, 0);
      access(0, "ld30", 1, 0, 3'b011, 64'h30, 0, 64'h0000000000001234, 2, 0);

      // The address holds data, but no request is made: output must be 0.
      mr = 0; mw = 0; f3 = 3'b011; addr = 64'h20;
      @(negedge clk);
      chk("noreq.rd",    rd,             64'd0);
      chk("noreq.stall", {63'd0, stall}, 64'd0);
      @(posedge clk);
      #1;

      // Reset in the second cycle of a store aborts it at once.
      mr = 0; mw = 1; f3 = 3'b011; addr = 64'h08; wdata = 64'hFFFFFFFFFFFFFFFF;
      @(negedge clk);
      chk("abort.stall1", {63'd0, stall}, 64'd1);
      @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      chk("abort.stall", {63'd0, stall}, 64'd0);
      chk("abort.rd",    rd,             64'd0);
      idle_all();
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      access(0, "ld08", 1, 0, 3'b011, 64'h08, 0, 64'd0, 2, 0);

      // Build with LATENCY=1: a store and a load are issued in alternate cycles.
      for (int k = 0; k < 6; k++) begin
         v = {$urandom, $urandom};
         access(1, "l1.sd", 0, 1, 3'b011, 64'(8*k), v, 64'd0, 0, 0);
         access(1, "l1.ld", 1, 0, 3'b011, 64'(8*k), 0, v, 0, 0);
      end
      idle_all();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/data_memory_stage.md
# data_memory_stage

Multi-cycle, byte-addressable data memory for the MEM stage of the 64-bit pipelined RISC-V core. Takes address, store data and control from the EX/MEM register and produces the sign- or zero-extended load value consumed by the MEM/WB register. Models a configurable access latency and raises a stall to the hazard unit while an access is in flight.

## Interface
- DEPTH_BYTES, 256: memory size in bytes; power of two, at least 8.
- LATENCY, 3: cycles per access; at least 1.
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- Mem_Addr  input  64  byte address (EX/MEM ALU result).
- Write_Data  input  64  store data (EX/MEM rs2 value).
- MemRead  input  1  load request.
- MemWrite  input  1  store request.
- funct3  input  3  access size and signedness (RISC-V load/store encoding).
- Read_Data  output  64  extended load result to MEM/WB.
- mem_stall  output  1  freezes PC, IF/ID, ID/EX and EX/MEM; inserts a bubble into MEM/WB.
- misaligned  output  1  the current access is misaligned and has been suppressed.

## Operation
- Storage: DEPTH_BYTES bytes, little-endian. Effective index is Mem_Addr modulo DEPTH_BYTES (low log2(DEPTH_BYTES) bits). Higher address bits are ignored, so accesses wrap around.
- Read is combinational from the array. A store commits at the posedge that ends the access's final cycle.
- Loads (funct3):
  - 000 lb, 001 lh, 010 lw, 011 ld: sign-extended.
  - 100 lbu, 101 lhu, 110 lwu: zero-extended.
  - 111: reserved. Read_Data=0, no error.
- Stores use funct3[1:0] (00 sb, 01 sh, 10 sw, 11 sd) and write only the addressed bytes, taken from the low bytes of Write_Data.
- Alignment: the address must be a multiple of the access size (1/2/4/8 bytes). A misaligned access behaves as follows:
  - misaligned=1 combinationally.
  - No array write; Read_Data=0.
  - mem_stall=0; the access completes in one cycle and the FSM stays in IDLE.
- If MemRead and MemWrite are both high, the store wins and Read_Data=0.
- Read_Data is 0 whenever MemRead is 0.
- FSM states are IDLE and WAIT, with a counter cnt of width clog2(LATENCY)+1.
  - IDLE, no request: mem_stall=0.
  - IDLE, aligned request, LATENCY=1: the access completes this cycle with mem_stall=0; stay in IDLE.
  - IDLE, aligned request, LATENCY>1: mem_stall=1; next state WAIT, cnt<=1.
  - WAIT, cnt<LATENCY-1: mem_stall=1; cnt<=cnt+1.
  - WAIT, cnt=LATENCY-1 (final cycle): mem_stall=0, Read_Data valid, store commits at the edge; next state IDLE.
- Upstream holds Mem_Addr, Write_Data, MemRead, MemWrite and funct3 stable while mem_stall=1. The block does not latch them.
- Reset clears the entire array to zero, forces the FSM to IDLE and cnt to 0. While reset is high, all outputs are 0.

## Timing
- Reset value of every output is 0: Read_Data=0, mem_stall=0, misaligned=0.
- An aligned access takes exactly LATENCY cycles: mem_stall is high for the first LATENCY-1 cycles and low in the final cycle.
- Load data is valid in the final cycle, before the posedge at which MEM/WB samples it.
- Back-to-back: a new request in the cycle after a final cycle starts a fresh access immediately. There is no idle gap.
- A load issued in the cycle after a store to the same address returns the new data.
- Reset asserted mid-access aborts the access: the pending store is discarded and mem_stall drops asynchronously.
- mem_stall and misaligned are combinational from the state and the inputs. There is no combinational path from Write_Data to mem_stall.

## Test plan
- Reset, then ld from 0x10 with LATENCY=3 -> mem_stall high for 2 cycles, then low; Read_Data=0x0 in cycle 3.
- sd 0x8877665544332211 to 0x20, then lb/lbu/lh/lw from 0x27, 0x27, 0x26, 0x24 -> 0xFFFFFFFFFFFFFF88, 0x88, 0xFFFFFFFFFFFF8877, 0xFFFFFFFF88776655.
- sb 0xAB to 0x21 over the data above, then ld 0x20 -> 0x887766554433AB11; the other bytes are unchanged.
- lw at 0x22 and sd at 0x104 -> misaligned=1, mem_stall=0, Read_Data=0, memory unchanged; then ld 0x100 with DEPTH_BYTES=256 -> wraps to the same bytes as 0x00.
- Assert reset during cycle 2 of an sd of 0xFF...FF to 0x08 -> mem_stall=0 immediately; a subsequent ld 0x08 returns 0.
- LATENCY=1 build: alternating sd/ld every cycle -> mem_stall never asserts; each ld returns the value of the immediately preceding sd.
